ps2_kbd_rx: RTL and testbench

Parametrised PS/2 keyboard receiver running entirely in the system clock domain. It synchronises and debounces the keyboard clock, frames 11-bit PS/2 packets, and decodes E0/E1/F0 prefix sequences into single make/break key events. Events are buffered in a FIFO with a valid/ready handshake, and the last received raw bytes drive a configurable number of 7-segment digit pairs. It replaces the fixed two-byte display receiver in the keyboard demo path.

---
 rtl/ps2_kbd_rx.sv | 316 +++++++++++++++++++++++++++++++
 tb/tb_ps2_kbd_rx.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: debounced framer, E0/E1/F0 prefix decoder, event FIFO, hex display.
// Define PS2_PARITY_CHECK_EN to discard frames whose odd parity fails. seg is active-high, bit 0 = a.
module ps2_kbd_rx #(
  parameter int unsigned DEB_CYCLES     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned DISP_BYTES     = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    kbclk,
  input  logic                    in,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [7:0]              evt_code,
  output logic                    evt_ext,
  output logic                    evt_brk,
  output logic                    frame_err,
  output logic                    ovf,
  output logic [14*DISP_BYTES-1:0] seg
);

  localparam int unsigned DebW  = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int unsigned TmoW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = AddrW + 1;
  localparam int unsigned HistW = 8 * DISP_BYTES;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} frm_state_e;
  typedef enum logic {StDecIdle, StDecPause} dec_state_e;

  // Input synchronisers and debounce
  logic [1:0]      kbclk_sync_q, in_sync_q;
  logic            kbclk_s, in_s;
  logic            deb_q, deb_d;
  logic [DebW-1:0] deb_cnt_q, deb_cnt_d;
  logic            fall;

  assign kbclk_s = kbclk_sync_q[1];
  assign in_s    = in_sync_q[1];

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (kbclk_s != deb_q) begin
      if (deb_cnt_q == DebW'(DEB_CYCLES - 1)) begin
        deb_d = kbclk_s;
      end else begin
        deb_cnt_d = deb_cnt_q + DebW'(1);
      end
    end
  end

  assign fall = deb_q & ~deb_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kbclk_sync_q <= 2'b11;
      in_sync_q    <= 2'b11;
      deb_q        <= 1'b1;
      deb_cnt_q    <= '0;
    end else begin
      kbclk_sync_q <= {kbclk_sync_q[0], kbclk};
      in_sync_q    <= {in_sync_q[0], in};
      deb_q        <= deb_d;
      deb_cnt_q    <= deb_cnt_d;
    end
  end

  // Framer
  frm_state_e      frm_q, frm_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            byte_done_q, byte_done_d;
  logic            frame_err_q, frame_err_d;
  logic [HistW-1:0] hist_q, hist_d;
  logic            par_ok;

  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    par_ok = ^{shift_q, par_q};
`else
    par_ok = 1'b1;
`endif
  end

  always_comb begin
    frm_d       = frm_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_d       = par_q;
    tmo_d       = '0;
    byte_done_d = 1'b0;
    frame_err_d = 1'b0;
    hist_d      = hist_q;
    unique case (frm_q)
      StIdle: begin
        if (fall && !in_s) begin
          frm_d     = StData;
          bit_cnt_d = 3'd0;
        end
      end
      StData: begin
        if (fall) begin
          shift_d   = {in_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) frm_d = StParity;
        end
      end
      StParity: begin
        if (fall) begin
          par_d = in_s;
          frm_d = StStop;
        end
      end
      StStop: begin
        if (fall) begin
          frm_d = StIdle;
          if (in_s && par_ok) begin
            byte_done_d = 1'b1;
            hist_d      = (hist_q << 8) | HistW'(shift_q);
          end else begin
            frame_err_d = 1'b1;
          end
        end
      end
    endcase
    // Gap timer runs only mid-frame and restarts on every fall
    if (frm_q != StIdle && !fall) begin
      if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        frm_d       = StIdle;
        frame_err_d = 1'b1;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frm_q       <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      par_q       <= 1'b0;
      tmo_q       <= '0;
      byte_done_q <= 1'b0;
      frame_err_q <= 1'b0;
      hist_q      <= '0;
    end else begin
      frm_q       <= frm_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_q       <= par_d;
      tmo_q       <= tmo_d;
      byte_done_q <= byte_done_d;
      frame_err_q <= frame_err_d;
      hist_q      <= hist_d;
    end
  end

  assign frame_err = frame_err_q;

  // Prefix decoder; the newest history byte is the byte just delivered
  dec_state_e dec_q, dec_d;
  logic       ext_q, ext_d, brk_q, brk_d;
  logic [2:0] pcnt_q, pcnt_d;
  logic       emit_q, emit_d;
  logic [7:0] emit_code_q, emit_code_d;
  logic       emit_ext_q, emit_ext_d, emit_brk_q, emit_brk_d;
  logic [7:0] rx_byte;

  assign rx_byte = hist_q[7:0];

  always_comb begin
    dec_d       = dec_q;
    ext_d       = ext_q;
    brk_d       = brk_q;
    pcnt_d      = pcnt_q;
    emit_d      = 1'b0;
    emit_code_d = emit_code_q;
    emit_ext_d  = emit_ext_q;
    emit_brk_d  = emit_brk_q;
    if (byte_done_q) begin
      unique case (dec_q)
        StDecPause: begin
          if (pcnt_q == 3'd6) begin
            emit_d      = 1'b1;
            emit_code_d = 8'h77;
            emit_ext_d  = 1'b1;
            emit_brk_d  = 1'b0;
            dec_d       = StDecIdle;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end else begin
            pcnt_d = pcnt_q + 3'd1;
          end
        end
        StDecIdle: begin
          if (rx_byte == 8'hE0) begin
            ext_d = 1'b1;
          end else if (rx_byte == 8'hF0) begin
            brk_d = 1'b1;
          end else if (rx_byte == 8'hE1) begin
            dec_d  = StDecPause;
            pcnt_d = 3'd0;
          end else begin
            emit_d      = 1'b1;
            emit_code_d = rx_byte;
            emit_ext_d  = ext_q;
            emit_brk_d  = brk_q;
            ext_d       = 1'b0;
            brk_d       = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_q       <= StDecIdle;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      pcnt_q      <= '0;
      emit_q      <= 1'b0;
      emit_code_q <= '0;
      emit_ext_q  <= 1'b0;
      emit_brk_q  <= 1'b0;
    end else begin
      dec_q       <= dec_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      pcnt_q      <= pcnt_d;
      emit_q      <= emit_d;
      emit_code_q <= emit_code_d;
      emit_ext_q  <= emit_ext_d;
      emit_brk_q  <= emit_brk_d;
    end
  end

  // Event FIFO, show-ahead
  logic [9:0]       mem_q [FIFO_DEPTH];
  logic [AddrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic             push, pop, full, do_push;

  assign push    = emit_q;
  assign pop     = evt_valid & evt_ready;
  assign full    = (cnt_q == CntW'(FIFO_DEPTH));
  assign do_push = push & (~full | pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    ovf_d    = ovf_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AddrW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AddrW'(1);
    if (do_push && !pop) begin
      cnt_d = cnt_q + CntW'(1);
    end else if (!do_push && pop) begin
      cnt_d = cnt_q - CntW'(1);
    end
    if (push && full && !pop) ovf_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= {emit_ext_q, emit_brk_q, emit_code_q};
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  assign evt_valid                     = (cnt_q != '0);
  assign {evt_ext, evt_brk, evt_code}  = mem_q[rd_ptr_q];
  assign ovf                           = ovf_q;

  // Hex display
  function automatic logic [6:0] hex7(input logic [3:0] n);
    unique case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      4'hF: hex7 = 7'h71;
    endcase
  endfunction

  for (genvar k = 0; k < 2 * DISP_BYTES; k++) begin : g_digit
    assign seg[7*k +: 7] = hex7(hist_q[4*k +: 4]);
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Self-checking bench for ps2_kbd_rx: directed scenarios plus randomized byte streams
// checked against a byte-level event model.
module tb_ps2_kbd_rx;

  localparam int unsigned DebCycles     = 8;
  localparam int unsigned TimeoutCycles = 1000;
  localparam int unsigned FifoDepth     = 4;
  localparam int unsigned DispBytes     = 2;
  localparam int unsigned SegW          = 14 * DispBytes;
  localparam int          Half          = 25;

  logic            clk;
  logic            rst_n;
  logic            kbclk;
  logic            ps2_data;
  logic            evt_valid;
  logic            evt_ready;
  logic [7:0]      evt_code;
  logic            evt_ext;
  logic            evt_brk;
  logic            frame_err;
  logic            ovf;
  logic [SegW-1:0] seg;

  int checks = 0;
  int passed = 0;
  int ferr_cnt = 0;
  logic [9:0] got_q[$];
  logic [9:0] exp_q[$];
  logic       m_ext, m_brk, m_pause;
  int         m_pcnt;
  logic [8*DispBytes-1:0] m_hist;
  logic       rnd_mode = 1'b0;

  ps2_kbd_rx #(
    .DEB_CYCLES    (DebCycles),
    .TIMEOUT_CYCLES(TimeoutCycles),
    .FIFO_DEPTH    (FifoDepth),
    .DISP_BYTES    (DispBytes)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .kbclk    (kbclk),
    .in       (ps2_data),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_code (evt_code),
    .evt_ext  (evt_ext),
    .evt_brk  (evt_brk),
    .frame_err(frame_err),
    .ovf      (ovf),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Consumer and frame_err observers, sampled mid-cycle
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (evt_valid && evt_ready) got_q.push_back({evt_ext, evt_brk, evt_code});
      if (frame_err) ferr_cnt++;
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1;
      evt_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1);
  end

  function automatic logic [6:0] hex7_ref(input logic [3:0] n);
    case (n)
      4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
      4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
      4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
      4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
    endcase
  endfunction

  function automatic logic [SegW-1:0] seg_ref(input logic [8*DispBytes-1:0] h);
    logic [SegW-1:0] s;
    for (int k = 0; k < 2 * DispBytes; k++) s[7*k +: 7] = hex7_ref(h[4*k +: 4]);
    return s;
  endfunction

  task automatic model_reset();
    m_ext = 1'b0; m_brk = 1'b0; m_pause = 1'b0; m_pcnt = 0; m_hist = '0;
    exp_q.delete();
    got_q.delete();
  endtask

  // Byte-level meaning of a delivered byte
  task automatic model_byte(input logic [7:0] b);
    m_hist = {m_hist[8*DispBytes-9:0], b};
    if (m_pause) begin
      m_pcnt++;
      if (m_pcnt == 7) begin
        exp_q.push_back({1'b1, 1'b0, 8'h77});
        m_pause = 1'b0; m_ext = 1'b0; m_brk = 1'b0;
      end
    end else if (b == 8'hE0) begin
      m_ext = 1'b1;
    end else if (b == 8'hF0) begin
      m_brk = 1'b1;
    end else if (b == 8'hE1) begin
      m_pause = 1'b1; m_pcnt = 0;
    end else begin
      exp_q.push_back({m_ext, m_brk, b});
      m_ext = 1'b0; m_brk = 1'b0;
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic b);
    ps2_data = b;
    wait_cyc(Half);
    kbclk = 1'b0;
    wait_cyc(Half);
    kbclk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par_flip, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit((~^b) ^ par_flip);
    drive_bit(stop);
    ps2_data = 1'b1;
    wait_cyc(20);
  endtask

  task automatic test_reset();
    checks++; if (evt_valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", evt_valid); else passed++;
    checks++; if (evt_code !== 8'h00) $display("FAIL reset_code: got %h expected 00", evt_code); else passed++;
    checks++; if ({evt_ext, evt_brk} !== 2'b00) $display("FAIL reset_flags: got %b expected 00", {evt_ext, evt_brk}); else passed++;
    checks++; if ({frame_err, ovf} !== 2'b00) $display("FAIL reset_err_ovf: got %b expected 00", {frame_err, ovf}); else passed++;
    checks++; if (seg !== seg_ref(m_hist)) $display("FAIL reset_seg: got %h expected %h", seg, seg_ref(m_hist)); else passed++;
  endtask

  task automatic test_basic();
    logic [SegW-1:0] s0;
    int t, lat;
    evt_ready = 1'b0;
    s0 = seg;
    model_byte(8'h1C);
    fork
      send_frame(8'h1C, 1'b0, 1'b1);
      begin
        t = 0;
        while (seg === s0 && t < 2000) begin wait_cyc(1); t++; end
        lat = 0;
        while (evt_valid !== 1'b1 && lat < 20) begin wait_cyc(1); lat++; end
        checks++;
        if (lat != 2 || t >= 2000) $display("FAIL basic_latency: got seg->valid %0d cycles (wait %0d) expected 2", lat, t);
        else passed++;
      end
    join
    checks++; if ({evt_ext, evt_brk, evt_code} !== exp_q[0]) $display("FAIL basic_head: got %h expected %h", {evt_ext, evt_brk, evt_code}, exp_q[0]); else passed++;
    checks++; if (seg[13:7] !== hex7_ref(4'h1) || seg[6:0] !== hex7_ref(4'hC)) $display("FAIL basic_digits: got %h_%h expected %h_%h", seg[13:7], seg[6:0], hex7_ref(4'h1), hex7_ref(4'hC)); else passed++;
    evt_ready = 1'b1; wait_cyc(2); evt_ready = 1'b0; wait_cyc(1);
    checks++; if (got_q.size() != 1 || evt_valid !== 1'b0) $display("FAIL basic_pop: got %0d events valid=%b expected 1 events valid=0", got_q.size(), evt_valid); else passed++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_prefix();
    logic [7:0] seq [3];
    seq[0] = 8'hE0; seq[1] = 8'hF0; seq[2] = 8'h75;
    evt_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin model_byte(seq[i]); send_frame(seq[i], 1'b0, 1'b1); end
    checks++; if ({evt_valid, evt_ext, evt_brk, evt_code} !== {1'b1, exp_q[0]}) $display("FAIL prefix_head: got %h expected %h", {evt_valid, evt_ext, evt_brk, evt_code}, {1'b1, exp_q[0]}); else passed++;
    evt_ready = 1'b1; wait_cyc(1); evt_ready = 1'b0; wait_cyc(2);
    checks++; if (got_q.size() != exp_q.size() || evt_valid !== 1'b0) $display("FAIL prefix_count: got %0d valid=%b expected %0d valid=0", got_q.size(), evt_valid, exp_q.size()); else passed++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_parity();
    int f0;
    f0 = ferr_cnt;
    evt_ready = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    send_frame(8'h1C, 1'b1, 1'b1);
    checks++; if (ferr_cnt - f0 != 1) $display("FAIL parity_err: got %0d pulses expected 1", ferr_cnt - f0); else passed++;
    checks++; if (evt_valid !== 1'b0) $display("FAIL parity_noevt: got valid %b expected 0", evt_valid); else passed++;
`else
    model_byte(8'h1C);
    send_frame(8'h1C, 1'b1, 1'b1);
    checks++; if (ferr_cnt - f0 != 0) $display("FAIL parity_err: got %0d pulses expected 0", ferr_cnt - f0); else passed++;
    checks++; if ({evt_valid, evt_ext, evt_brk, evt_code} !== {1'b1, exp_q[0]}) $display("FAIL parity_evt: got %h expected %h", {evt_valid, evt_ext, evt_brk, evt_code}, {1'b1, exp_q[0]}); else passed++;
    evt_ready = 1'b1; wait_cyc(2); evt_ready = 1'b0;
`endif
    checks++; if (seg !== seg_ref(m_hist)) $display("FAIL parity_seg: got %h expected %h", seg, seg_ref(m_hist)); else passed++;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_timeout();
    int f0;
    f0 = ferr_cnt;
    evt_ready = 1'b0;
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'($urandom_range(0, 1)));
    ps2_data = 1'b1;
    wait_cyc(TimeoutCycles + 200);
    checks++; if (ferr_cnt - f0 != 1) $display("FAIL timeout_err: got %0d pulses expected 1", ferr_cnt - f0); else passed++;
    model_byte(8'h29);
    send_frame(8'h29, 1'b0, 1'b1);
    checks++; if ({evt_valid, evt_ext, evt_brk, evt_code} !== {1'b1, exp_q[0]}) $display("FAIL timeout_next: got %h expected %h", {evt_valid, evt_ext, evt_brk, evt_code}, {1'b1, exp_q[0]}); else passed++;
    evt_ready = 1'b1; wait_cyc(2); evt_ready = 1'b0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_overflow();
    logic [7:0] codes [5];
    codes[0] = 8'h15; codes[1] = 8'h1D; codes[2] = 8'h24; codes[3] = 8'h2D; codes[4] = 8'h2C;
    evt_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      model_byte(codes[i]);
      send_frame(codes[i], 1'b0, 1'b1);
      if (i == FifoDepth - 1) begin
        checks++; if (ovf !== 1'b0) $display("FAIL ovf_at_full: got %b expected 0", ovf); else passed++;
      end
    end
    while (exp_q.size() > FifoDepth) void'(exp_q.pop_back());
    checks++; if ({evt_valid, ovf} !== 2'b11) $display("FAIL ovf_set: got valid/ovf %b expected 11", {evt_valid, ovf}); else passed++;
    evt_ready = 1'b1; wait_cyc(10); evt_ready = 1'b0;
    checks++; if (got_q.size() != exp_q.size() || evt_valid !== 1'b0) $display("FAIL ovf_drain: got %0d valid=%b expected %0d valid=0", got_q.size(), evt_valid, exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL ovf_order[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); else passed++;
    end
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_reset_midframe();
    int f0;
    f0 = ferr_cnt;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(1'($urandom_range(0, 1)));
    rst_n = 1'b0;
    model_reset();
    wait_cyc(2);
    checks++; if ({evt_valid, evt_ext, evt_brk, evt_code, frame_err, ovf} !== 13'h0) $display("FAIL rst_mid_outs: got %h expected 0", {evt_valid, evt_ext, evt_brk, evt_code, frame_err, ovf}); else passed++;
    checks++; if (seg !== seg_ref(m_hist)) $display("FAIL rst_mid_seg: got %h expected %h", seg, seg_ref(m_hist)); else passed++;
    rst_n = 1'b1;
    wait_cyc(5);
    model_byte(8'h5A);
    send_frame(8'h5A, 1'b0, 1'b1);
    checks++; if ({evt_valid, evt_ext, evt_brk, evt_code} !== {1'b1, exp_q[0]}) $display("FAIL rst_mid_next: got %h expected %h", {evt_valid, evt_ext, evt_brk, evt_code}, {1'b1, exp_q[0]}); else passed++;
    checks++; if (ferr_cnt != f0) $display("FAIL rst_mid_noerr: got %0d pulses expected 0", ferr_cnt - f0); else passed++;
    evt_ready = 1'b1; wait_cyc(2); evt_ready = 1'b0;
    exp_q.delete(); got_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] bytes[$];
    logic [7:0] b;
    int kind, n_e1, f0, n_bad;
    logic bad;
    n_e1 = 0; n_bad = 0;
    f0 = ferr_cnt;
    for (int i = 0; i < 20; i++) begin
      kind = (i == 5) ? 3 : int'($urandom_range(0, 9));
      if (kind <= 1) bytes.push_back(8'hE0);
      else if (kind == 2) bytes.push_back(8'hF0);
      else if (kind == 3 && n_e1 < 2) begin
        n_e1++;
        bytes.push_back(8'hE1);
        for (int j = 0; j < 7; j++) bytes.push_back(8'($urandom_range(0, 255)));
      end else begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hE0 || b == 8'hE1 || b == 8'hF0) b = 8'h1C;
        bytes.push_back(b);
      end
    end
    rnd_mode = 1'b1;
    foreach (bytes[i]) begin
      bad = ($urandom_range(0, 5) == 0);
      if (bad) n_bad++; else model_byte(bytes[i]);
      send_frame(bytes[i], 1'b0, !bad);
    end
    rnd_mode = 1'b0;
    wait_cyc(2);
    evt_ready = 1'b1; wait_cyc(10); evt_ready = 1'b0;
    checks++; if (got_q.size() != exp_q.size()) $display("FAIL rnd_count: got %0d events expected %0d", got_q.size(), exp_q.size()); else passed++;
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++; if (got_q[i] !== exp_q[i]) $display("FAIL rnd_evt[%0d]: got %h expected %h", i, got_q[i], exp_q[i]); else passed++;
    end
    checks++; if (ferr_cnt - f0 != n_bad) $display("FAIL rnd_ferr: got %0d pulses expected %0d", ferr_cnt - f0, n_bad); else passed++;
    checks++; if (seg !== seg_ref(m_hist)) $display("FAIL rnd_seg: got %h expected %h", seg, seg_ref(m_hist)); else passed++;
    checks++; if ({evt_valid, ovf} !== 2'b00) $display("FAIL rnd_final: got valid/ovf %b expected 00", {evt_valid, ovf}); else passed++;
    exp_q.delete(); got_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    kbclk = 1'b1;
    ps2_data = 1'b1;
    evt_ready = 1'b0;
    model_reset();
    wait_cyc(5);
    rst_n = 1'b1;
    wait_cyc(5);
    test_reset();
    test_basic();
    test_prefix();
    test_parity();
    test_timeout();
    test_overflow();
    test_reset_midframe();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
